operand_loader: RTL and testbench
=================================

OPERAND_LOADER -- requirements
Module: operand_loader

Interface
REQ-001 Parameter DEB_CYCLES, default 16, sets the number of consecutive stable synchronized samples needed to accept a key level change (range 2..65535).
REQ-002 CLK  input  1  system clock; all state changes on its rising edge.
REQ-003 RESETN  input  1  asynchronous, active-low reset.
REQ-004 SwIn  input  8  operand value from the switch bank; asynchronous to CLK.
REQ-005 KeyLoad  input  1  raw push-button, active-low, bouncing; each press loads one operand.
REQ-006 KeyClr  input  1  raw push-button, active-low, bouncing; each press clears both operands.
REQ-007 DataA  output  8  first operand, registered; feeds the comparator stage's DataA.
REQ-008 DataB  output  8  second operand, registered; feeds the comparator stage's DataB.
REQ-009 Valid  output  1  high while both DataA and DataB hold a freshly loaded pair.
REQ-010 StateOut  output  2  current FSM state encoding, for LED display.

Function
REQ-011 SwIn, KeyLoad and KeyClr shall each pass through a 2-flop synchronizer before any other use.
REQ-012 Each key shall drive a saturating stability counter that resets on any change of the synchronized level.
REQ-013 The debounced level shall change only after DEB_CYCLES consecutive equal synchronized samples.
REQ-014 A debounced high-to-low transition shall produce exactly one 1-cycle press pulse.
REQ-015 A key held low indefinitely shall produce no further pulses.
REQ-016 Glitches shorter than DEB_CYCLES samples shall produce no pulse.
REQ-017 The FSM shall have three states: EMPTY=0, HAVE_A=1, READY=2; encoding 3 is illegal and shall recover to EMPTY on the next cycle.
REQ-018 In EMPTY, a load pulse shall set DataA to the synchronized SwIn and move to HAVE_A.
REQ-019 In HAVE_A, a load pulse shall set DataB to the synchronized SwIn, move to READY, and raise Valid.
REQ-020 In READY, a load pulse shall set DataA to SwIn, set DataB to 0, drop Valid, and move to HAVE_A.
REQ-021 A clear pulse in any state shall set DataA=DataB=0, drop Valid, and move to EMPTY.
REQ-022 When clear and load pulses fall in the same cycle, clear shall win and the load shall be discarded.
REQ-023 Valid shall equal (state==READY), registered, so that it changes in the same cycle as DataB.
REQ-024 DataA and DataB shall hold their values in every cycle without a qualifying pulse.
REQ-025 Latency from a clean key fall at the pin to the output update shall be 2 + DEB_CYCLES + 1 cycles.

Reset
REQ-026 While RESETN=0, outputs shall be: DataA=0, DataB=0, Valid=0, StateOut=EMPTY.
REQ-027 While RESETN=0, all synchronizers and debounced levels shall be 1 (released) and the counters 0.
REQ-028 Reset asserted mid-debounce or mid-sequence shall abort it; a key still held at reset release shall not generate a pulse until it has been released and pressed again.

Structure
REQ-029 The state encodings EMPTY, HAVE_A and READY, and the DEB_CYCLES default, shall live in the shared package operand_pkg.
REQ-030 Synchronizer, stability counter and edge pulse shall form sub-module key_debounce, instantiated once for KeyLoad and once for KeyClr.
REQ-031 The FSM and operand registers shall reside in operand_loader itself.

Verification (DEB_CYCLES=4)
REQ-032 Reset release with keys high -> all outputs 0, StateOut=0, and no pulses for 50 cycles.
REQ-033 SwIn=0x5A, press KeyLoad cleanly; then SwIn=0x3C, press again -> DataA=0x5A, then DataB=0x3C, Valid=1, StateOut=2; each update lands exactly 7 cycles after its press.
REQ-034 KeyLoad bouncing (low 2, high 1, low 3 cycles) then held low for 20 cycles -> exactly one pulse and one load.
REQ-035 From READY, press KeyLoad with SwIn=0xFF -> DataA=0xFF, DataB=0, Valid=0, StateOut=1.
REQ-036 Press KeyClr and KeyLoad in the same cycle while in HAVE_A -> EMPTY with both operands 0; no load occurs.
REQ-037 Assert RESETN for 1 cycle while KeyLoad is held, then release -> outputs reset; no load occurs until KeyLoad is released and pressed again.

Source files
------------

// File: rtl/operand_pkg.sv
// Shared definitions for the operand loader: FSM state encoding, operand width
// and the default key debounce length.
package operand_pkg;

  localparam int DATA_W             = 8;
  localparam int DEB_CYCLES_DEFAULT = 16;

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    HAVE_A = 2'd1,
    READY  = 2'd2
  } loadState_e;

endpackage

// File: rtl/key_debounce.sv
// Active-low push-button conditioner: 2-flop synchronizer, stability counter
// and a single-cycle press pulse on each accepted high-to-low change.
module key_debounce
  import operand_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic resetN,
  input  logic keyN,
  output logic pressPulse
);

  // cntR holds (consecutive equal samples - 1); a level is accepted when the
  // current sample makes the run DEB_CYCLES long.
  localparam logic [15:0] ACCEPT_CNT = 16'(DEB_CYCLES - 2);
  localparam logic [15:0] SAT_CNT    = 16'(DEB_CYCLES - 1);

  logic        sync1R;
  logic        sync2R;
  logic        lastR;
  logic        debR;
  logic        armedR;
  logic        pulseR;
  logic [1:0]  startR;
  logic [15:0] cntR;

  // Synchronizer, stability counter, debounced level and registered press pulse.
  // The first two samples after reset are reset values, not the pin, so they
  // are not counted. armedR stays low until a released level has been
  // accepted, so a key held through reset cannot fire.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      sync1R <= 1'b1;
      sync2R <= 1'b1;
      lastR  <= 1'b1;
      debR   <= 1'b1;
      armedR <= 1'b0;
      pulseR <= 1'b0;
      startR <= 2'b00;
      cntR   <= 16'd0;
    end else begin
      sync1R <= keyN;
      sync2R <= sync1R;
      startR <= {startR[0], 1'b1};
      if (!startR[1]) begin
        cntR   <= 16'd0;
        lastR  <= sync2R;
        pulseR <= 1'b0;
      end else if (sync2R != lastR) begin
        cntR   <= 16'd0;
        lastR  <= sync2R;
        pulseR <= 1'b0;
      end else if (cntR == ACCEPT_CNT) begin
        cntR   <= SAT_CNT;
        debR   <= sync2R;
        armedR <= armedR | sync2R;
        pulseR <= armedR & debR & ~sync2R;
      end else begin
        if (cntR < SAT_CNT) begin
          cntR <= cntR + 16'd1;
        end else begin
          cntR <= SAT_CNT;
        end
        pulseR <= 1'b0;
      end
    end
  end

  assign pressPulse = pulseR;

endmodule

// File: rtl/operand_loader.sv
// Collects two operands from a switch bank, one per debounced KeyLoad press,
// for the comparator stage; KeyClr empties both operands.
module operand_loader
  import operand_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
  input  logic              CLK,
  input  logic              RESETN,
  input  logic [DATA_W-1:0] SwIn,
  input  logic              KeyLoad,
  input  logic              KeyClr,
  output logic [DATA_W-1:0] DataA,
  output logic [DATA_W-1:0] DataB,
  output logic              Valid,
  output logic [1:0]        StateOut
);

  logic [DATA_W-1:0] swSync1R;
  logic [DATA_W-1:0] swSync2R;
  logic              loadPulse;
  logic              clrPulse;
  loadState_e        stateR;
  logic [DATA_W-1:0] dataAR;
  logic [DATA_W-1:0] dataBR;
  logic              validR;

  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) uLoadKey (
    .clk       (CLK),
    .resetN    (RESETN),
    .keyN      (KeyLoad),
    .pressPulse(loadPulse)
  );

  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) uClrKey (
    .clk       (CLK),
    .resetN    (RESETN),
    .keyN      (KeyClr),
    .pressPulse(clrPulse)
  );

  // Two-flop synchronizer for the switch bank.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      swSync1R <= {DATA_W{1'b1}};
      swSync2R <= {DATA_W{1'b1}};
    end else begin
      swSync1R <= SwIn;
      swSync2R <= swSync1R;
    end
  end

  // Operand FSM; clear takes priority over a load landing in the same cycle.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      stateR <= EMPTY;
      dataAR <= {DATA_W{1'b0}};
      dataBR <= {DATA_W{1'b0}};
      validR <= 1'b0;
    end else if (clrPulse) begin
      stateR <= EMPTY;
      dataAR <= {DATA_W{1'b0}};
      dataBR <= {DATA_W{1'b0}};
      validR <= 1'b0;
    end else if (loadPulse) begin
      case (stateR)
        EMPTY: begin
          stateR <= HAVE_A;
          dataAR <= swSync2R;
          dataBR <= dataBR;
          validR <= 1'b0;
        end
        HAVE_A: begin
          stateR <= READY;
          dataAR <= dataAR;
          dataBR <= swSync2R;
          validR <= 1'b1;
        end
        READY: begin
          stateR <= HAVE_A;
          dataAR <= swSync2R;
          dataBR <= {DATA_W{1'b0}};
          validR <= 1'b0;
        end
        default: begin
          stateR <= EMPTY;
          dataAR <= {DATA_W{1'b0}};
          dataBR <= {DATA_W{1'b0}};
          validR <= 1'b0;
        end
      endcase
    end else begin
      case (stateR)
        EMPTY, HAVE_A, READY: begin
          stateR <= stateR;
          dataAR <= dataAR;
          dataBR <= dataBR;
          validR <= validR;
        end
        default: begin
          stateR <= EMPTY;
          dataAR <= {DATA_W{1'b0}};
          dataBR <= {DATA_W{1'b0}};
          validR <= 1'b0;
        end
      endcase
    end
  end

  assign DataA    = dataAR;
  assign DataB    = dataBR;
  assign Valid    = validR;
  assign StateOut = stateR;

endmodule

// File: tb/tb_operand_loader.sv
// Randomized and directed bench for operand_loader (DEB_CYCLES=4) against a
// cycle-level behavioural model built from pin histories and operand counts.
module tb_operand_loader;

  localparam int DEB = 4;

  logic       CLK = 1'b0;
  logic       RESETN;
  logic [7:0] SwIn;
  logic       KeyLoad;
  logic       KeyClr;
  logic [7:0] DataA;
  logic [7:0] DataB;
  logic       Valid;
  logic [1:0] StateOut;

  operand_loader #(.DEB_CYCLES(DEB)) dut (
    .CLK     (CLK),
    .RESETN  (RESETN),
    .SwIn    (SwIn),
    .KeyLoad (KeyLoad),
    .KeyClr  (KeyClr),
    .DataA   (DataA),
    .DataB   (DataB),
    .Valid   (Valid),
    .StateOut(StateOut)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: pins seen two edges late, runs of equal samples per key,
  // and the operand store as a count of held operands (0, 1 or 2).
  int         edgeCnt;
  logic [7:0] swD1, swD2;
  logic       ldD1, ldD2, clD1, clD2;
  logic       prevS [2];
  logic       debS  [2];
  logic       armS  [2];
  int         runS  [2];
  logic       pendLd, pendCl;
  logic [7:0] mA, mB;
  int         nOps;

  task automatic modelReset();
    edgeCnt = 0;
    swD1 = 8'hFF; swD2 = 8'hFF;
    ldD1 = 1'b1; ldD2 = 1'b1; clD1 = 1'b1; clD2 = 1'b1;
    for (int k = 0; k < 2; k++) begin
      prevS[k] = 1'b1; debS[k] = 1'b1; armS[k] = 1'b0; runS[k] = 1;
    end
    pendLd = 1'b0; pendCl = 1'b0;
    mA = 8'h00; mB = 8'h00; nOps = 0;
  endtask

  task automatic keyModel(input int k, input logic smp, output logic press);
    press = 1'b0;
    if (smp != prevS[k]) begin
      prevS[k] = smp;
      runS[k]  = 1;
    end else begin
      runS[k]++;
      if (runS[k] == DEB) begin
        press   = (smp == 1'b0) && debS[k] && armS[k];
        debS[k] = smp;
        if (smp) armS[k] = 1'b1;
      end
    end
  endtask

  task automatic modelStep(input logic ld, input logic cl, input logic [7:0] sw);
    logic nLd, nCl;
    edgeCnt++;
    if (pendCl) begin
      mA = 8'h00; mB = 8'h00; nOps = 0;
    end else if (pendLd) begin
      if (nOps == 0)      begin mA = swD2; nOps = 1; end
      else if (nOps == 1) begin mB = swD2; nOps = 2; end
      else                begin mA = swD2; mB = 8'h00; nOps = 1; end
    end
    nLd = 1'b0; nCl = 1'b0;
    if (edgeCnt > 2) begin
      keyModel(0, ldD2, nLd);
      keyModel(1, clD2, nCl);
    end
    pendLd = nLd; pendCl = nCl;
    swD2 = swD1; swD1 = sw;
    ldD2 = ldD1; ldD1 = ld;
    clD2 = clD1; clD1 = cl;
  endtask

  task automatic checkOuts(input string pfx);
    checkEq({pfx, "_dataA"}, DataA, mA);
    checkEq({pfx, "_dataB"}, DataB, mB);
    checkEq({pfx, "_valid"}, Valid, (nOps == 2) ? 1'b1 : 1'b0);
    checkEq({pfx, "_state"}, StateOut, nOps[1:0]);
  endtask

  task automatic tick();
    logic ld, cl;
    logic [7:0] sw;
    ld = KeyLoad; cl = KeyClr; sw = SwIn;
    @(posedge CLK);
    #1;
    modelStep(ld, cl, sw);
    checkOuts("cyc");
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic applyReset();
    RESETN = 1'b0;
    #1;
    modelReset();
    checkOuts("rst_async");
    @(posedge CLK);
    #1;
    checkOuts("rst_hold");
    RESETN = 1'b1;
  endtask

  task automatic pressLoad(input logic [7:0] v, input int hold, input int rel);
    SwIn = v; KeyLoad = 1'b0; run(hold);
    KeyLoad = 1'b1; run(rel);
  endtask

  task automatic pressClr(input int hold, input int rel);
    KeyClr = 1'b0; run(hold);
    KeyClr = 1'b1; run(rel);
  endtask

  initial begin
    RESETN = 1'b0; SwIn = 8'h00; KeyLoad = 1'b1; KeyClr = 1'b1;
    #2;
    applyReset();

    // Idle after reset: no pulses, outputs stay cleared.
    run(50);
    checkEq("idle_state", StateOut, 2'd0);

    // Two clean loads with exact 7-cycle latency.
    SwIn = 8'h5A; run(3);
    KeyLoad = 1'b0; run(6);
    checkEq("lat_a_pre", DataA, 8'h00);
    run(1);
    checkEq("lat_a_post", DataA, 8'h5A);
    checkEq("lat_a_state", StateOut, 2'd1);
    run(10); KeyLoad = 1'b1; run(10);
    SwIn = 8'h3C; run(3);
    KeyLoad = 1'b0; run(6);
    checkEq("lat_b_pre", DataB, 8'h00);
    checkEq("lat_b_vpre", Valid, 1'b0);
    run(1);
    checkEq("lat_b_post", DataB, 8'h3C);
    checkEq("lat_b_valid", Valid, 1'b1);
    checkEq("lat_b_state", StateOut, 2'd2);
    checkEq("lat_b_keepA", DataA, 8'h5A);
    run(10); KeyLoad = 1'b1; run(10);

    // Load from READY restarts the pair.
    pressLoad(8'hFF, 10, 10);
    checkEq("ready_ld_a", DataA, 8'hFF);
    checkEq("ready_ld_b", DataB, 8'h00);
    checkEq("ready_ld_v", Valid, 1'b0);
    checkEq("ready_ld_st", StateOut, 2'd1);

    // Bouncing press yields exactly one load.
    pressClr(10, 10);
    SwIn = 8'h11; run(3);
    KeyLoad = 1'b0; run(2); KeyLoad = 1'b1; run(1); KeyLoad = 1'b0; run(3);
    run(20); KeyLoad = 1'b1; run(10);
    checkEq("bounce_a", DataA, 8'h11);
    checkEq("bounce_st", StateOut, 2'd1);

    // Simultaneous clear and load in HAVE_A: clear wins.
    SwIn = 8'h99;
    KeyLoad = 1'b0; KeyClr = 1'b0; run(10);
    KeyLoad = 1'b1; KeyClr = 1'b1; run(10);
    checkEq("both_st", StateOut, 2'd0);
    checkEq("both_a", DataA, 8'h00);
    checkEq("both_b", DataB, 8'h00);

    // Reset while KeyLoad held: no load until released and pressed again.
    pressLoad(8'h77, 10, 10);
    KeyLoad = 1'b0; run(3);
    applyReset();
    run(30);
    checkEq("held_st", StateOut, 2'd0);
    checkEq("held_a", DataA, 8'h00);
    KeyLoad = 1'b1; run(10);
    checkEq("held_rel_st", StateOut, 2'd0);
    pressLoad(8'h42, 10, 10);
    checkEq("repress_a", DataA, 8'h42);
    checkEq("repress_st", StateOut, 2'd1);

    // Randomized episodes checked cycle by cycle against the model.
    for (int ep = 0; ep < 200; ep++) begin
      int kind;
      kind = $urandom_range(0, 9);
      case (kind)
        0, 1, 2, 3: pressLoad(8'($urandom), $urandom_range(DEB + 2, 12), $urandom_range(DEB + 2, 10));
        4: pressClr($urandom_range(DEB + 2, 10), $urandom_range(DEB + 2, 8));
        5: begin
          SwIn = 8'($urandom);
          for (int s = 0; s < int'($urandom_range(1, 4)); s++) begin
            KeyLoad = 1'b0; run($urandom_range(1, 3));
            KeyLoad = 1'b1; run($urandom_range(1, 3));
          end
          KeyLoad = 1'b0; run(8); KeyLoad = 1'b1; run(8);
        end
        6: begin
          SwIn = 8'($urandom);
          KeyLoad = 1'b0; run($urandom_range(1, DEB - 1));
          KeyLoad = 1'b1; run(6);
        end
        7: begin
          SwIn = 8'($urandom);
          KeyLoad = 1'b0; KeyClr = 1'b0; run($urandom_range(DEB + 2, 10));
          KeyLoad = 1'b1; KeyClr = 1'b1; run(8);
        end
        8: begin
          SwIn = 8'($urandom); run(5);
        end
        default: begin
          if ($urandom_range(0, 3) == 0) begin
            KeyLoad = 1'($urandom); KeyClr = 1'($urandom);
            applyReset();
            run(8);
            KeyLoad = 1'b1; KeyClr = 1'b1; run(8);
          end else begin
            run(3);
          end
        end
      endcase
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
